axi_read_protocol: RTL and testbench

- Read-side companion to the team's AXI write-protocol FSM: drives the AR and R channels of one AXI port for property verification and ILA modelling.
- Accepts read-address requests and slave read data from free inputs.
- Produces legal AR/R handshakes, burst beat counting, RLAST and the per-beat address.
- Sits beside the write FSM under the same verification top.

---
 rtl/axi_fsm_pkg.sv | 23 ++
 rtl/axi_beat_addr_gen.sv | 32 +++
 rtl/axi_read_protocol.sv | 165 ++++++++++++++++
 tb/tb_axi_read_protocol.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_fsm_pkg.sv
// Shared state, burst and response encodings for the AXI read and write protocol FSMs.
package axi_fsm_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_COMMIT = 2'b01,
        ST_ASSERT = 2'b10
    } fsm_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only 2/4/8/16-beat wrapping bursts are legal; anything else falls back to INCR.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts, modulo 2^AW.
module axi_beat_addr_gen
    import axi_fsm_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic [7:0]    len,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] inc;
    logic [AW-1:0] wrap_bytes;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] incr_addr;

    always_comb begin
        inc        = AW'(1) << size;
        wrap_bytes = AW'({1'b0, len} + 9'd1) << size;
        wrap_mask  = wrap_bytes - AW'(1);
        incr_addr  = addr + inc;
        next_addr  = incr_addr;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && wrap_len_legal(len)) begin
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end
    end

endmodule

// File: rtl/axi_read_protocol.sv
// AXI AR/R channel protocol model: legal handshakes, burst beat counting, RLAST and beat address.
// valid/ready: a transfer happens in every cycle an FSM sits in COMMIT (valid=1, ready=1); in ASSERT the payload is held with ready=0.
module axi_read_protocol
    import axi_fsm_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          axi_aclk,
    input  logic          rst,
    input  logic [AW-1:0] araddr_in,
    input  logic [7:0]    arlen_in,
    input  logic [2:0]    arsize_in,
    input  logic [1:0]    arburst_in,
    input  logic          arvalid_in,
    input  logic [DW-1:0] rdata_in,
    input  logic [1:0]    rresp_in,
    input  logic          rvalid_in,
    input  logic          rready_in,
    output logic [AW-1:0] axi_araddr,
    output logic [7:0]    axi_arlen,
    output logic [2:0]    axi_arsize,
    output logic [1:0]    axi_arburst,
    output logic          axi_arvalid,
    output logic          axi_arready,
    output logic [DW-1:0] axi_rdata,
    output logic [1:0]    axi_rresp,
    output logic          axi_rlast,
    output logic          axi_rvalid,
    output logic          axi_rready,
    output logic [AW-1:0] axi_rbeat_addr,
    output fsm_state_t    ar_state,
    output fsm_state_t    r_state,
    output logic          r_active
);

    logic [7:0]    remaining;
    logic [7:0]    b_len;
    logic [2:0]    b_size;
    logic [1:0]    b_burst;
    logic [AW-1:0] next_addr;
    logic [1:0]    resp_now;

    assign resp_now = (b_burst == BURST_RSVD) ? RESP_SLVERR : rresp_in;

    axi_beat_addr_gen #(.AW(AW)) u_addr_gen (
        .addr      (axi_rbeat_addr),
        .size      (b_size),
        .len       (b_len),
        .burst     (b_burst),
        .next_addr (next_addr)
    );

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            ar_state       <= ST_WAIT;
            r_state        <= ST_WAIT;
            r_active       <= 1'b0;
            remaining      <= '0;
            b_len          <= '0;
            b_size         <= '0;
            b_burst        <= '0;
            axi_araddr     <= '0;
            axi_arlen      <= '0;
            axi_arsize     <= '0;
            axi_arburst    <= '0;
            axi_arvalid    <= 1'b0;
            axi_arready    <= 1'b1;
            axi_rdata      <= '0;
            axi_rresp      <= '0;
            axi_rlast      <= 1'b0;
            axi_rvalid     <= 1'b0;
            axi_rready     <= 1'b0;
            axi_rbeat_addr <= '0;
        end else begin
            // R channel; data is only accepted once its address has been handed over
            case (r_state)
                ST_WAIT: begin
                    if (r_active && rvalid_in) begin
                        axi_rdata  <= rdata_in;
                        axi_rresp  <= resp_now;
                        axi_rvalid <= 1'b1;
                        axi_rready <= rready_in;
                        r_state    <= rready_in ? ST_COMMIT : ST_ASSERT;
                    end else begin
                        axi_rready <= rready_in;
                    end
                end
                ST_COMMIT: begin
                    remaining      <= remaining - 8'd1;
                    axi_rbeat_addr <= next_addr;
                    axi_rlast      <= (remaining == 8'd1);
                    if (axi_rlast) begin
                        r_active   <= 1'b0;
                        axi_rlast  <= 1'b0;
                        axi_rvalid <= 1'b0;
                        axi_rready <= 1'b0;
                        r_state    <= ST_WAIT;
                    end else if (rvalid_in) begin
                        axi_rdata  <= rdata_in;
                        axi_rresp  <= resp_now;
                        axi_rready <= rready_in;
                        r_state    <= rready_in ? ST_COMMIT : ST_ASSERT;
                    end else begin
                        axi_rvalid <= 1'b0;
                        axi_rready <= rready_in;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_ASSERT: begin
                    if (rready_in) begin
                        axi_rready <= 1'b1;
                        r_state    <= ST_COMMIT;
                    end
                end
                default: r_state <= ST_WAIT;
            endcase

            // AR channel; placed last so an AR handshake wins any shared register
            case (ar_state)
                ST_WAIT: begin
                    if (arvalid_in) begin
                        axi_araddr  <= araddr_in;
                        axi_arlen   <= arlen_in;
                        axi_arsize  <= arsize_in;
                        axi_arburst <= arburst_in;
                        axi_arvalid <= 1'b1;
                        axi_arready <= ~r_active;
                        ar_state    <= r_active ? ST_ASSERT : ST_COMMIT;
                    end else begin
                        axi_arready <= ~r_active;
                    end
                end
                ST_COMMIT: begin
                    r_active       <= 1'b1;
                    remaining      <= axi_arlen;
                    axi_rbeat_addr <= axi_araddr;
                    axi_rlast      <= (axi_arlen == 8'd0);
                    b_len          <= axi_arlen;
                    b_size         <= axi_arsize;
                    b_burst        <= axi_arburst;
                    axi_arready    <= 1'b0;
                    if (arvalid_in) begin
                        axi_araddr  <= araddr_in;
                        axi_arlen   <= arlen_in;
                        axi_arsize  <= arsize_in;
                        axi_arburst <= arburst_in;
                        ar_state    <= ST_ASSERT;
                    end else begin
                        axi_arvalid <= 1'b0;
                        ar_state    <= ST_WAIT;
                    end
                end
                ST_ASSERT: begin
                    if (!r_active) begin
                        axi_arready <= 1'b1;
                        ar_state    <= ST_COMMIT;
                    end
                end
                default: ar_state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_protocol.sv
// Directed bench for axi_read_protocol: AR/R handshakes, beat addresses, RLAST, backpressure and reset.
module tb_axi_read_protocol;
    import axi_fsm_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          axi_aclk;
    logic          rst;
    logic [AW-1:0] araddr_in;
    logic [7:0]    arlen_in;
    logic [2:0]    arsize_in;
    logic [1:0]    arburst_in;
    logic          arvalid_in;
    logic [DW-1:0] rdata_in;
    logic [1:0]    rresp_in;
    logic          rvalid_in;
    logic          rready_in;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [AW-1:0] axi_rbeat_addr;
    fsm_state_t    ar_state;
    fsm_state_t    r_state;
    logic          r_active;

    int vec_cnt = 0;
    int mis_cnt = 0;
    logic [AW-1:0] exp_q[$];

    axi_read_protocol #(.AW(AW), .DW(DW)) dut (
        .axi_aclk       (axi_aclk),
        .rst            (rst),
        .araddr_in      (araddr_in),
        .arlen_in       (arlen_in),
        .arsize_in      (arsize_in),
        .arburst_in     (arburst_in),
        .arvalid_in     (arvalid_in),
        .rdata_in       (rdata_in),
        .rresp_in       (rresp_in),
        .rvalid_in      (rvalid_in),
        .rready_in      (rready_in),
        .axi_araddr     (axi_araddr),
        .axi_arlen      (axi_arlen),
        .axi_arsize     (axi_arsize),
        .axi_arburst    (axi_arburst),
        .axi_arvalid    (axi_arvalid),
        .axi_arready    (axi_arready),
        .axi_rdata      (axi_rdata),
        .axi_rresp      (axi_rresp),
        .axi_rlast      (axi_rlast),
        .axi_rvalid     (axi_rvalid),
        .axi_rready     (axi_rready),
        .axi_rbeat_addr (axi_rbeat_addr),
        .ar_state       (ar_state),
        .r_state        (r_state),
        .r_active       (r_active)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue_ar(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        araddr_in  = addr;
        arlen_in   = len;
        arsize_in  = size;
        arburst_in = burst;
        arvalid_in = 1'b1;
        step();
        chk("ar_handshake", axi_arvalid & axi_arready, 1);
        arvalid_in = 1'b0;
    endtask

    task automatic wait_active();
        for (int c = 0; c < 10; c++) begin
            if (r_active) break;
            step();
        end
        chk("wait_active", r_active, 1);
    endtask

    // Observes R COMMIT cycles and scores each beat against exp_q.
    task automatic collect(input int n, input logic [1:0] exp_resp, input logic [DW-1:0] exp_data);
        int cnt;
        logic [AW-1:0] ea;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < n; c++) begin
            step();
            if (axi_rvalid && axi_rready) begin
                ea = exp_q.pop_front();
                chk("beat_addr", axi_rbeat_addr, ea);
                chk("beat_rlast", axi_rlast, (cnt == n - 1));
                chk("beat_rresp", axi_rresp, exp_resp);
                chk("beat_rdata", axi_rdata, exp_data);
                cnt++;
            end
        end
        chk("beat_count", cnt, n);
        step();
        chk("rvalid_after_burst", axi_rvalid, 0);
        chk("r_active_after_burst", r_active, 0);
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_arvalid"}, axi_arvalid, 0);
        chk({tag, "_arready"}, axi_arready, 1);
        chk({tag, "_rvalid"}, axi_rvalid, 0);
        chk({tag, "_rready"}, axi_rready, 0);
        chk({tag, "_rlast"}, axi_rlast, 0);
        chk({tag, "_araddr"}, axi_araddr, 0);
        chk({tag, "_rdata"}, axi_rdata, 0);
        chk({tag, "_rbeat_addr"}, axi_rbeat_addr, 0);
        chk({tag, "_r_active"}, r_active, 0);
        chk({tag, "_states"}, {ar_state, r_state}, 4'b0000);
    endtask

    int beats;

    initial begin
        rst = 1'b1;
        araddr_in = '0; arlen_in = '0; arsize_in = '0; arburst_in = '0; arvalid_in = 1'b0;
        rdata_in = '0; rresp_in = '0; rvalid_in = 1'b0; rready_in = 1'b0;
        step();
        step();
        check_reset_values("reset");

        // Single beat; rvalid_in early must be ignored until the address is taken
        rst = 1'b0;
        araddr_in = 32'h1000; arlen_in = 8'd0; arsize_in = 3'd3; arburst_in = BURST_INCR;
        arvalid_in = 1'b1; rvalid_in = 1'b1; rready_in = 1'b1; rdata_in = 64'h1111;
        step();
        chk("single_ar_hs", axi_arvalid & axi_arready, 1);
        chk("single_ar_state", ar_state, ST_COMMIT);
        chk("single_araddr", axi_araddr, 32'h1000);
        arvalid_in = 1'b0;
        step();
        chk("single_r_active", r_active, 1);
        chk("single_no_early_data", axi_rvalid, 0);
        step();
        chk("single_r_commit", r_state, ST_COMMIT);
        chk("single_rvalid_rready", {axi_rvalid, axi_rready}, 2'b11);
        chk("single_rlast", axi_rlast, 1);
        chk("single_rresp", axi_rresp, RESP_OKAY);
        chk("single_beat_addr", axi_rbeat_addr, 32'h1000);
        chk("single_rdata", axi_rdata, 64'h1111);
        step();
        chk("single_rvalid_drop", axi_rvalid, 0);
        chk("single_r_active_drop", r_active, 0);

        // INCR len=3 size=2
        rdata_in = 64'h2222_0000_0000_0001;
        exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        issue_ar(32'h100, 8'd3, 3'd2, BURST_INCR);
        collect(4, RESP_OKAY, 64'h2222_0000_0000_0001);

        // WRAP len=3 size=2 from the middle of the 16-byte window
        rdata_in = 64'h3333;
        exp_q = '{32'h108, 32'h10C, 32'h100, 32'h104};
        issue_ar(32'h108, 8'd3, 3'd2, BURST_WRAP);
        collect(4, RESP_OKAY, 64'h3333);

        // WRAP with illegal len=2 behaves as INCR
        rdata_in = 64'h4444;
        exp_q = '{32'h108, 32'h10C, 32'h110};
        issue_ar(32'h108, 8'd2, 3'd2, BURST_WRAP);
        collect(3, RESP_OKAY, 64'h4444);

        // FIXED keeps the address; slave response passes through
        rdata_in = 64'h5555; rresp_in = 2'b01;
        exp_q = '{32'h300, 32'h300};
        issue_ar(32'h300, 8'd1, 3'd3, BURST_FIXED);
        collect(2, 2'b01, 64'h5555);

        // Reserved burst: counted as INCR, every beat SLVERR
        rdata_in = 64'h6666; rresp_in = RESP_OKAY;
        exp_q = '{32'h200, 32'h204};
        issue_ar(32'h200, 8'd1, 3'd2, BURST_RSVD);
        collect(2, RESP_SLVERR, 64'h6666);

        // R backpressure: data held in ASSERT until rready_in
        rvalid_in = 1'b0; rready_in = 1'b0;
        issue_ar(32'h400, 8'd0, 3'd3, BURST_INCR);
        wait_active();
        rdata_in = 64'hA5; rvalid_in = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("bp_state", r_state, ST_ASSERT);
            chk("bp_valid_ready", {axi_rvalid, axi_rready}, 2'b10);
            chk("bp_rdata_held", axi_rdata, 64'hA5);
            rdata_in = {32'h0, $urandom_range(32'hFFFF_FFFF, 0)};
            step();
        end
        rready_in = 1'b1;
        step();
        chk("bp_commit", r_state, ST_COMMIT);
        chk("bp_rready", axi_rready, 1);
        chk("bp_rdata_final", axi_rdata, 64'hA5);
        chk("bp_rlast", axi_rlast, 1);
        chk("bp_beat_addr", axi_rbeat_addr, 32'h400);
        rvalid_in = 1'b0;
        step();
        chk("bp_rvalid_drop", axi_rvalid, 0);

        // Second request arrives during a 4-beat burst
        rready_in = 1'b0;
        issue_ar(32'h500, 8'd3, 3'd2, BURST_INCR);
        wait_active();
        araddr_in = 32'h600; arlen_in = 8'd0; arsize_in = 3'd3; arburst_in = BURST_INCR;
        arvalid_in = 1'b1; rvalid_in = 1'b1; rready_in = 1'b1; rdata_in = 64'hBEEF;
        step();
        arvalid_in = 1'b0;
        chk("ovl_ar_assert", ar_state, ST_ASSERT);
        chk("ovl_arready_low", axi_arready, 0);
        chk("ovl_arvalid", axi_arvalid, 1);
        beats = (axi_rvalid && axi_rready) ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            if (!r_active) break;
            step();
            if (axi_rvalid && axi_rready) beats++;
        end
        chk("ovl_first_beats", beats, 4);
        chk("ovl_still_assert", ar_state, ST_ASSERT);
        chk("ovl_arready_still_low", axi_arready, 0);
        chk("ovl_payload_stable", {axi_araddr, axi_arlen}, {32'h600, 8'd0});
        step();
        chk("ovl_ar_commit", ar_state, ST_COMMIT);
        chk("ovl_ar_hs", axi_arvalid & axi_arready, 1);
        exp_q = '{32'h600};
        collect(1, RESP_OKAY, 64'hBEEF);

        // Reset in the middle of an 8-beat burst
        rdata_in = 64'h7777;
        issue_ar(32'h700, 8'd7, 3'd2, BURST_INCR);
        for (int c = 0; c < 10; c++) begin
            step();
            if (axi_rvalid && axi_rready) break;
        end
        chk("mid_rst_in_burst", axi_rvalid & axi_rready, 1);
        rst = 1'b1;
        step();
        check_reset_values("mid_rst");
        rst = 1'b0; rvalid_in = 1'b0; rready_in = 1'b0;
        step();
        chk("post_rst_arready", axi_arready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
